// File: rtl/ads124x_scan_seq.sv
// ads124x_scan_seq
// Autonomous channel-scan sequencer for an ADS124x behind an 8-bit AXIS SPI
// byte master. It round-robins over the enabled slots. For each slot it
// writes MUX0, waits for DRDY (skipping DISCARD conversions), issues RDATA,
// and emits the 24-bit result tagged with the slot index.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   enable            : run request; dropping it mid-slot finishes the SPI
//                       command in flight, suppresses output, returns to IDLE
//   ch_mask, ch_mux   : per-slot enable and MUX0 value (slot i = [8i+7:8i])
//   drdy              : ADS124x DRDY (active-low, asynchronous)
//   spitx_*           : command bytes towards the SPI master (AXIS)
//   spirx_*           : bytes returned by the SPI master (always accepted)
//   m_axis_*          : samples, tdata = {slot[3:0], 4'h0, sample[23:0]}
//   busy              : not IDLE
//   stat_timeout      : sticky, a slot was abandoned waiting for DRDY
//   stat_overrun      : sticky, DRDY fell while a sample was waiting in OUT
module ads124x_scan_seq #(
    parameter int NUM_CH  = 8,
    parameter int DISCARD = 1,
    parameter int TIMEOUT = 2**20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [NUM_CH*8-1:0] ch_mux,
    input  logic                drdy,
    output logic [7:0]          spitx_tdata,
    output logic                spitx_tvalid,
    input  logic                spitx_tready,
    input  logic [7:0]          spirx_tdata,
    input  logic                spirx_tvalid,
    output logic                spirx_tready,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                stat_timeout,
    output logic                stat_overrun
);
    localparam int              PW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]      DISC_N   = 4'(DISCARD);
    localparam logic [PW-1:0]   PTR_LAST = PW'(NUM_CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_WREG, S_WAIT, S_RDATA, S_OUT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr;
    logic [3:0]    slot;
    logic [7:0]    mux_q;
    logic [1:0]    byte_idx;
    logic          tx_pend;
    logic          abort_q;
    logic [3:0]    disc_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [23:0]   sample;
    logic          drdy_p0, drdy_p1, drdy_p2;
    logic          enable_q;

    logic          drdy_evt, rx_done, abort, sel_found;
    logic [PW-1:0] sel_idx;
    logic [7:0]    mux_sel;
    logic [PW:0]   cand;

    assign drdy_evt = drdy_p2 & ~drdy_p1;
    // Only the byte we are waiting for counts; anything else (IDLE, stale
    // bytes after reset) is silently drained.
    assign rx_done  = tx_pend & spirx_tvalid;
    assign abort    = abort_q | ~enable;

    // First set mask bit at or after ptr, wrapping. The loop runs from the
    // far end so the nearest candidate is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_CH))
                cand = cand - (PW+1)'(NUM_CH);
            if (ch_mask[cand[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        mux_sel = 8'h00;
        for (int i = 0; i < NUM_CH; i++)
            if (sel_idx == PW'(i))
                mux_sel = ch_mux[8*i +: 8];
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (enable && |ch_mask) state_n = S_SEL;
            S_SEL:   state_n = (enable && sel_found) ? S_WREG : S_IDLE;
            S_WREG:  if (rx_done && byte_idx == 2'd2) state_n = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (!enable)
                    state_n = S_IDLE;
                else if (drdy_evt && disc_cnt == DISC_N)
                    state_n = S_RDATA;
                else if (tmo_cnt == TMO_LAST)
                    state_n = S_SEL;
            end
            S_RDATA: if (rx_done && byte_idx == 2'd3) state_n = abort ? S_IDLE : S_OUT;
            S_OUT:   if (m_axis_tready) state_n = enable ? S_SEL : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign spitx_tvalid  = (state == S_WREG || state == S_RDATA) && !tx_pend;
    assign spirx_tready  = 1'b1;
    assign m_axis_tvalid = (state == S_OUT);
    assign m_axis_tdata  = m_axis_tvalid ? {slot, 4'h0, sample} : 32'h0;
    assign busy          = (state != S_IDLE);

    // byte_idx only moves on rx, so tdata holds while tvalid && !tready.
    always_comb begin
        spitx_tdata = 8'h00;
        if (spitx_tvalid) begin
            if (state == S_WREG) begin
                case (byte_idx)
                    2'd0:    spitx_tdata = 8'h40;
                    2'd1:    spitx_tdata = 8'h00;
                    default: spitx_tdata = mux_q;
                endcase
            end else begin
                spitx_tdata = (byte_idx == 2'd0) ? 8'h12 : 8'hFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            byte_idx     <= '0;
            tx_pend      <= 1'b0;
            abort_q      <= 1'b0;
            disc_cnt     <= '0;
            tmo_cnt      <= '0;
            stat_timeout <= 1'b0;
            stat_overrun <= 1'b0;
            enable_q     <= 1'b0;
            drdy_p0      <= 1'b1;
            drdy_p1      <= 1'b1;
            drdy_p2      <= 1'b1;
        end else begin
            drdy_p0  <= drdy;
            drdy_p1  <= drdy_p0;
            drdy_p2  <= drdy_p1;
            enable_q <= enable;
            state    <= state_n;

            if (spitx_tvalid && spitx_tready)
                tx_pend <= 1'b1;
            else if (rx_done)
                tx_pend <= 1'b0;

            if (state_n != state)
                byte_idx <= '0;
            else if (rx_done)
                byte_idx <= byte_idx + 2'd1;

            if (state == S_SEL && state_n == S_WREG)
                ptr <= (sel_idx == PTR_LAST) ? '0 : sel_idx + PW'(1);

            if (state_n == S_IDLE)
                abort_q <= 1'b0;
            else if (!enable && (state == S_WREG || state == S_WAIT || state == S_RDATA))
                abort_q <= 1'b1;

            if (state == S_WREG) begin
                disc_cnt <= '0;
                tmo_cnt  <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (drdy_evt && disc_cnt != DISC_N)
                    disc_cnt <= disc_cnt + 4'd1;
            end

            if (enable && !enable_q) begin
                stat_timeout <= 1'b0;
                stat_overrun <= 1'b0;
            end else begin
                if (state == S_WAIT && state_n == S_SEL)
                    stat_timeout <= 1'b1;
                if (state == S_OUT && drdy_evt)
                    stat_overrun <= 1'b1;
            end
        end
    end

    // Slot data path: no reset, only observed while valid.
    always_ff @(posedge clk) begin
        if (state == S_SEL) begin
            slot  <= 4'(sel_idx);
            mux_q <= mux_sel;
        end
        if (state == S_RDATA && rx_done && byte_idx != 2'd0)
            sample <= {sample[15:0], spirx_tdata};
    end

endmodule

// File: tb/tb_ads124x_scan_seq.sv
// Bench for ads124x_scan_seq: NUM_CH=4, DISCARD=1, TIMEOUT=1000.
// An SPI slave model returns random MISO bytes after random delays and
// logs every transmitted byte; the expected command stream, slot order and
// sample words are derived from the logs and a round-robin slot model.
module tb_ads124x_scan_seq;
    localparam int NCH  = 4;
    localparam int DISC = 1;
    localparam int TMO  = 1000;

    logic        clk;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  ch_mask = 4'h0;
    logic [31:0] ch_mux = 32'h0;
    logic        drdy = 1'b1;
    logic [7:0]  spitx_tdata;
    logic        spitx_tvalid;
    logic        spitx_tready = 1'b0;
    logic [7:0]  spirx_tdata = 8'h00;
    logic        spirx_tvalid = 1'b0;
    logic        spirx_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        busy;
    logic        stat_timeout;
    logic        stat_overrun;

    ads124x_scan_seq #(.NUM_CH(NCH), .DISCARD(DISC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .ch_mux(ch_mux),
        .drdy(drdy),
        .spitx_tdata(spitx_tdata), .spitx_tvalid(spitx_tvalid), .spitx_tready(spitx_tready),
        .spirx_tdata(spirx_tdata), .spirx_tvalid(spirx_tvalid), .spirx_tready(spirx_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .stat_timeout(stat_timeout), .stat_overrun(stat_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] tx_log[$];
    logic [7:0] miso_log[$];
    logic       resp_pend = 1'b0;
    int         resp_dly = 0;
    logic [7:0] resp_byte = 8'h00;
    logic       slow = 1'b0;
    int         vld_cycles = 0;

    // SPI slave: one reply byte per accepted command byte.
    always @(negedge clk) begin
        spirx_tvalid = 1'b0;
        if (resp_pend) begin
            if (resp_dly == 0) begin
                spirx_tvalid = 1'b1;
                spirx_tdata  = resp_byte;
                resp_pend    = 1'b0;
            end else begin
                resp_dly = resp_dly - 1;
            end
        end
        spitx_tready = ($urandom_range(0, 3) != 0);
        if (spitx_tvalid && spitx_tready) begin
            tx_log.push_back(spitx_tdata);
            resp_byte = 8'($urandom);
            miso_log.push_back(resp_byte);
            resp_pend = 1'b1;
            resp_dly  = slow ? 6 : int'($urandom_range(0, 3));
        end
    end

    always @(negedge clk)
        if (m_axis_tvalid) vld_cycles = vld_cycles + 1;

    int n_cmp = 0;
    int n_err = 0;
    int tx_pos = 0;
    int mptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int t;
        t = 0;
        while (tx_log.size() < n && t < 400) begin
            tick();
            t++;
        end
        chk({tag, "_txwait"}, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic drdy_fall();
        drdy = 1'b0;
        repeat (3) tick();
        drdy = 1'b1;
        repeat (3) tick();
    endtask

    // Round robin: first enabled slot at or after the pointer, wrapping.
    function automatic int next_slot();
        logic [3:0] mk;
        int i;
        mk = ch_mask;
        for (int k = 0; k < NCH; k++) begin
            i = (mptr + k) % NCH;
            if (mk[i]) begin
                mptr = (i + 1) % NCH;
                return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [7:0] mux_of(input int s);
        logic [31:0] mx;
        mx = ch_mux;
        return mx[8*s +: 8];
    endfunction

    task automatic chk_wreg(input string tag, input int p, input int s);
        chk({tag, "_w0"}, 32'(tx_log[p]),   32'h40);
        chk({tag, "_w1"}, 32'(tx_log[p+1]), 32'h00);
        chk({tag, "_w2"}, 32'(tx_log[p+2]), 32'(mux_of(s)));
    endtask

    task automatic chk_rdata(input string tag, input int p);
        chk({tag, "_r0"}, 32'(tx_log[p+3]), 32'h12);
        for (int j = 4; j < 7; j++)
            chk({tag, "_rff"}, 32'(tx_log[p+j]), 32'hFF);
    endtask

    // One complete slot: MUX0 write, DISC skipped conversions, RDATA, sample.
    task automatic run_slot(input string tag, input bit wreg_pulse, input int hold, input bit stop);
        int s, p, w;
        logic [3:0] sl;
        logic [31:0] exp;
        s  = next_slot();
        sl = 4'(s);
        p  = tx_pos;
        if (wreg_pulse) begin
            wait_tx(tag, p + 1);
            drdy_fall();
        end
        wait_tx(tag, p + 3);
        chk_wreg(tag, p, s);
        repeat (12) tick();
        for (int d = 0; d < DISC; d++) begin
            drdy_fall();
            repeat (6) tick();
            chk({tag, "_disc"}, 32'(tx_log.size()), 32'(p + 3));
        end
        drdy_fall();
        wait_tx(tag, p + 7);
        chk_rdata(tag, p);
        w = 0;
        while (!m_axis_tvalid && w < 200) begin
            tick();
            w++;
        end
        exp = {sl, 4'h0, miso_log[p+4], miso_log[p+5], miso_log[p+6]};
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        chk({tag, "_tdata"}, m_axis_tdata, exp);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (hold > 0) begin
            chk({tag, "_ovr0"}, 32'(stat_overrun), 32'd0);
            for (int c = 0; c < hold; c++) begin
                drdy = ((c / 5) % 2 == 0) ? 1'b0 : 1'b1;
                tick();
                if (c % 50 == 49) begin
                    chk({tag, "_hold_vld"}, 32'(m_axis_tvalid), 32'd1);
                    chk({tag, "_hold_data"}, m_axis_tdata, exp);
                end
            end
            drdy = 1'b1;
            tick();
            chk({tag, "_ovr1"}, 32'(stat_overrun), 32'd1);
        end else begin
            repeat ($urandom_range(0, 4)) tick();
        end
        chk({tag, "_tdata_hold"}, m_axis_tdata, exp);
        if (stop) enable = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        tx_pos = p + 7;
    endtask

    initial begin : main
        int s, p, v0;

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txvalid", 32'(spitx_tvalid), 32'd0);
        chk("rst_txdata", 32'(spitx_tdata), 32'd0);
        chk("rst_rxready", 32'(spirx_tready), 32'd1);
        chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_mdata", m_axis_tdata, 32'd0);
        chk("rst_tmo", 32'(stat_timeout), 32'd0);
        chk("rst_ovr", 32'(stat_overrun), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Enabled but empty mask: stays idle.
        enable = 1'b1;
        repeat (8) tick();
        chk("nomask_busy", 32'(busy), 32'd0);
        chk("nomask_tx", 32'(tx_log.size()), 32'd0);
        enable = 1'b0;
        tick();

        // Directed slots 0 and 2, including a DRDY fall during WREG.
        ch_mask = 4'b0101;
        ch_mux  = 32'h67234501;
        enable  = 1'b1;
        slow    = 1'b1;
        run_slot("a0", 1'b1, 0, 1'b0);
        slow    = 1'b0;
        run_slot("a1", 1'b0, 0, 1'b0);
        run_slot("a2", 1'b0, 0, 1'b0);
        chk("a_ovr", 32'(stat_overrun), 32'd0);
        chk("a_tmo", 32'(stat_timeout), 32'd0);

        // No DRDY: slot abandoned after TIMEOUT, no sample.
        s  = next_slot();
        p  = tx_pos;
        v0 = vld_cycles;
        wait_tx("tmo", p + 3);
        chk_wreg("tmo", p, s);
        repeat (900) tick();
        chk("tmo_early", 32'(stat_timeout), 32'd0);
        chk("tmo_early_tx", 32'(tx_log.size()), 32'(p + 3));
        repeat (200) tick();
        chk("tmo_set", 32'(stat_timeout), 32'd1);
        chk("tmo_noout", 32'(vld_cycles), 32'(v0));
        tx_pos = p + 3;
        run_slot("after_tmo", 1'b0, 0, 1'b0);

        // Back-pressure with DRDY toggling.
        run_slot("hold", 1'b0, 500, 1'b0);

        // Enable dropped in the middle of RDATA.
        s  = next_slot();
        p  = tx_pos;
        v0 = vld_cycles;
        wait_tx("abt", p + 3);
        chk_wreg("abt", p, s);
        repeat (12) tick();
        for (int d = 0; d < DISC; d++) drdy_fall();
        drdy = 1'b0;
        wait_tx("abt", p + 4);
        enable = 1'b0;
        drdy   = 1'b1;
        wait_tx("abt", p + 7);
        repeat (20) tick();
        chk("abt_txcount", 32'(tx_log.size()), 32'(p + 7));
        chk_rdata("abt", p);
        chk("abt_busy", 32'(busy), 32'd0);
        chk("abt_noout", 32'(vld_cycles), 32'(v0));
        tx_pos = p + 7;
        chk("abt_tmo_sticky", 32'(stat_timeout), 32'd1);
        chk("abt_ovr_sticky", 32'(stat_overrun), 32'd1);

        // Random masks and MUX values; enable rise clears the stats.
        ch_mask = 4'($urandom_range(1, 15));
        ch_mux  = $urandom;
        enable  = 1'b1;
        repeat (2) tick();
        chk("en_clr_tmo", 32'(stat_timeout), 32'd0);
        chk("en_clr_ovr", 32'(stat_overrun), 32'd0);
        for (int t = 0; t < 6; t++)
            run_slot("rnd", 1'b0, 0, (t == 5));
        repeat (5) tick();
        chk("rnd_idle", 32'(busy), 32'd0);

        // Reset in the middle of WREG.
        ch_mask = 4'hF;
        ch_mux  = $urandom;
        enable  = 1'b1;
        wait_tx("rstw", tx_pos + 2);
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_txvalid", 32'(spitx_tvalid), 32'd0);
        chk("rstw_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rstw_mdata", m_axis_tdata, 32'd0);
        chk("rstw_rxready", 32'(spirx_tready), 32'd1);
        rst = 1'b0;
        repeat (20) tick();
        tx_pos = tx_log.size();
        mptr   = 0;
        enable = 1'b1;
        run_slot("post_rst", 1'b0, 0, 1'b1);
        repeat (5) tick();
        chk("end_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ads124x_scan_seq.md
Name: ads124x_scan_seq

Overview:
Autonomous channel-scan sequencer for the ADS124x SPI byte-stream master. It round-robins over enabled channels and, for each, writes the MUX0 register, waits for DRDY, and issues RDATA. Each 24-bit result is tagged with its channel index and emitted on an AXI4-Stream sample port. It sits between the register bank (config/enable) and the 8-bit TX/RX AXIS ports of the SPI master, in place of manual CPU byte pushing.

Parameters:
NUM_CH, 8, number of scan slots (1..16)
DISCARD, 1, conversions skipped after each MUX0 write before the one read (0..15)
TIMEOUT, 2**20, clk cycles to wait for DRDY before aborting the slot

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
enable  in  1  scan run; sampled in IDLE/SEL, abort request elsewhere
ch_mask  in  NUM_CH  per-slot enable
ch_mux  in  NUM_CH*8  per-slot MUX0 value, slot i = bits [8i+7:8i]
drdy  in  1  ADS124x DRDY, active-low, asynchronous (2-flop sync inside)
spitx_tdata  out  8  command byte to SPI master
spitx_tvalid  out  1  AXIS valid
spitx_tready  in  1  AXIS ready
spirx_tdata  in  8  byte returned per transmitted byte
spirx_tvalid  in  1  AXIS valid
spirx_tready  out  1  constant 1
m_axis_tdata  out  32  {ch[3:0], 4'h0, sample[23:0]}
m_axis_tvalid  out  1  sample valid
m_axis_tready  in  1  sample ready
busy  out  1  high in any state except IDLE
stat_timeout  out  1  sticky: DRDY timeout occurred
stat_overrun  out  1  sticky: DRDY fell while in OUT

Behaviour:
- Reset: state IDLE, slot pointer 0, all outputs 0 except spirx_tready=1; stats cleared. Stats also clear on rising edge of enable.
- drdy synchronised by 2 flops; event = synced falling edge (1-cycle pulse).
- One byte outstanding: next tx byte presented only after the rx byte for the previous one is received. spitx_tdata stable while tvalid && !tready. rx bytes arriving in IDLE are dropped.
- States:
  IDLE: if enable && |ch_mask -> SEL; else stay (busy=0).
  SEL: pick first set mask bit at index >= ptr, wrapping to 0; ptr <= chosen+1 (mod NUM_CH). Mask sampled here only. Mask all zero -> IDLE. -> WREG.
  WREG: send 0x40, 0x00, ch_mux[slot]; after 3rd rx byte, clear discard counter and timeout counter -> WAIT. DRDY events during WREG are ignored.
  WAIT: on DRDY event: if disc_cnt < DISCARD, disc_cnt++ and stay; else -> RDATA. Timeout counter reaching TIMEOUT-1 -> set stat_timeout -> SEL (slot skipped, no output).
  RDATA: send 0x12, 0xFF, 0xFF, 0xFF; 1st rx byte discarded, rx bytes 2..4 shifted into sample MSB first. After 4th rx byte -> OUT.
  OUT: m_axis_tvalid=1, data stable until tready. On handshake -> SEL (or IDLE if !enable). DRDY event while in OUT sets stat_overrun.
- enable low outside IDLE/SEL/OUT: finish current command sequence (no partial SPI commands), suppress output, -> IDLE.
- Sample latency after chosen DRDY event: 2 sync cycles + 4 SPI byte times + 1 cycle to tvalid.
- Slot index >= NUM_CH never selected; NUM_CH=1 rewrites MUX0 every sample.
- Reset mid-transaction: immediate IDLE; stale rx bytes are drained by constant spirx_tready.

Test Plan:
- NUM_CH=4, DISCARD=0, mask=4'b0101, ch_mux slot0=0x01, slot2=0x23; SPI model echoes MISO 0xAB,0xCD,0xEF -> tx bytes 40 00 01 12 FF FF FF, sample 0x00ABCDEF, then 40 00 23 ..., tdata 0x20ABCDEF; then slot0 again.
- DISCARD=2, single slot -> first two DRDY falls after WREG ignored, RDATA after third; DRDY fall during WREG not counted.
- No DRDY, TIMEOUT=1000 -> after 1000 cycles in WAIT stat_timeout=1, next enabled slot WREG issued, no m_axis output.
- m_axis_tready held low 500 cycles with DRDY toggling -> tvalid/tdata stable, stat_overrun=1; after tready, scan continues at next slot.
- enable dropped mid-RDATA -> all 4 RDATA bytes still sent, no output, busy=0 thereafter; rst during WREG byte 2 -> next cycle IDLE, spitx_tvalid=0, outputs at reset values.
